// File: rtl/bcd_timer_ctrl.sv
// Sequencer for a chain of NDIG external BCD up/down digit counters: prescaled tick, load, carry decode, terminal stop.
// Define BCD_CTRL_AUTORELOAD_EN to make DONE a one-cycle pulse that reloads the latched preset (periodic timer).
module bcd_timer_ctrl #(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 50000
) (
    input  logic                clk,
    input  logic                a_clr,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                dir,
    input  logic [4*NDIG-1:0]   preset,
    input  logic [4*NDIG-1:0]   digits,
    output logic [2*NDIG-1:0]   mode_o,
    output logic                load_en_o,
    output logic [4*NDIG-1:0]   load_o,
    output logic                busy,
    output logic                done,
    output logic                tick_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE,
        S_CLR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     presc;
    logic              dir_q;
    logic [4*NDIG-1:0] preset_q;
    logic [4*NDIG-1:0] preset_clamped;
    logic              tick;
    logic              terminal;
    logic              latch_en;
    logic              carry;

    always_comb begin
        preset_clamped = preset;
        for (int i = 0; i < NDIG; i++) begin
            if (preset[4*i +: 4] > 4'd9) preset_clamped[4*i +: 4] = 4'd9;
        end
    end

    assign tick     = (state == S_RUN) && (presc == PRESC_LAST);
    assign terminal = dir_q ? (digits == preset_q) : (digits == '0);
    assign latch_en = (state_nxt == S_LOAD) && start && ((state == S_IDLE) || (state == S_DONE));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge a_clr) begin
        if (!a_clr) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_CLR;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_RUN;
                S_RUN: begin
                    if (stop)                  state_nxt = S_PAUSE;
                    else if (tick && terminal) state_nxt = S_DONE;
                end
                S_PAUSE: if (start) state_nxt = S_RUN;
`ifdef BCD_CTRL_AUTORELOAD_EN
                S_DONE:  state_nxt = stop ? S_IDLE : S_LOAD;
`else
                S_DONE:  if (start) state_nxt = S_LOAD;
`endif
                S_CLR:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Prescaler only advances in RUN, so PAUSE freezes it and resume continues mid-period.
    always_ff @(posedge clk or negedge a_clr) begin
        if (!a_clr) begin
            presc    <= '0;
            dir_q    <= 1'b0;
            preset_q <= '0;
        end else begin
            if (state == S_LOAD)     presc <= '0;
            else if (state == S_RUN) presc <= tick ? '0 : presc + 1'b1;
            if (latch_en) begin
                dir_q    <= dir;
                preset_q <= preset_clamped;
            end
        end
    end

    always_comb begin
        mode_o    = '0;
        carry     = 1'b1;
        load_en_o = (state == S_LOAD) || (state == S_CLR);
        load_o    = ((state == S_LOAD) && !dir_q) ? preset_q : '0;
        busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_PAUSE);
        done      = (state == S_DONE);
        tick_o    = tick;
        // Ripple carry/borrow decoded from live digits so all digits step on the same edge.
        if (tick && !terminal) begin
            for (int i = 0; i < NDIG; i++) begin
                if (carry) mode_o[2*i +: 2] = dir_q ? 2'b01 : 2'b10;
                carry = carry && (digits[4*i +: 4] == (dir_q ? 4'd9 : 4'd0));
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: models the external BCD digit chain, scoreboards load strobes and decoded modes.
module tb_bcd_timer_ctrl;

    localparam int NDIG     = 4;
    localparam int TICK_DIV = 4;

    logic        clk = 1'b0;
    logic        a_clr;
    logic        start, stop, clear, dir;
    logic [15:0] preset, digits;
    logic [7:0]  mode_o;
    logic        load_en_o;
    logic [15:0] load_o;
    logic        busy, done, tick_o;

    logic        chain_en;
    logic [15:0] chain_q, digits_force;

    int total = 0;
    int bad   = 0;
    logic [15:0] load_q[$];
    logic [7:0]  mode_q[$];

    typedef struct {
        logic        dir;
        logic [15:0] preset;
        logic [15:0] digits;
        logic [7:0]  mode;
        logic        done;
    } vec_t;
    vec_t vecs[14];

    bcd_timer_ctrl #(.NDIG(NDIG), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .a_clr(a_clr), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .preset(preset), .digits(digits), .mode_o(mode_o),
        .load_en_o(load_en_o), .load_o(load_o), .busy(busy), .done(done), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    assign digits = chain_en ? chain_q : digits_force;

    function automatic logic [15:0] chain_step(input logic [15:0] d, input logic [7:0] m);
        logic [15:0] r;
        logic [3:0]  v;
        r = d;
        for (int i = 0; i < 4; i++) begin
            v = d[4*i +: 4];
            case (m[2*i +: 2])
                2'b01:   r[4*i +: 4] = (v == 4'd9) ? 4'd0 : v + 4'd1;
                2'b10:   r[4*i +: 4] = (v == 4'd0) ? 4'd9 : v - 4'd1;
                default: ;
            endcase
        end
        return r;
    endfunction

    // External digit chain sharing the reset.
    always @(posedge clk or negedge a_clr) begin
        if (!a_clr)         chain_q <= '0;
        else if (load_en_o) chain_q <= load_o;
        else                chain_q <= chain_step(chain_q, mode_o);
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] clamp(input logic [15:0] p);
        logic [15:0] r;
        r = p;
        for (int i = 0; i < 4; i++) if (p[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick_o && n < 40);
        if (!tick_o) check("tick_timeout", tick_o, 1);
    endtask

    task automatic do_start(input logic d, input logic [15:0] p);
        dir    = d;
        preset = p;
        start  = 1'b1;
        load_q.push_back(d ? 16'h0000 : clamp(p));
        cyc(1);
        start = 1'b0;
        check("load_strobe", load_en_o, 1);
        check("load_busy", busy, 1);
    endtask

    // Scoreboard: every load strobe and every forced-digit tick must match a queued expectation.
    always @(negedge clk) begin
        if (load_en_o) begin
            if (load_q.size() == 0) check("load_unexpected", load_en_o, 0);
            else                    check("load_value", load_o, load_q.pop_front());
        end
        if (tick_o && !chain_en) begin
            if (mode_q.size() == 0) check("mode_unexpected", tick_o, 0);
            else                    check("mode_value", mode_o, mode_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] em;
        vecs[0]  = '{1'b0, 16'h1234, 16'h0000, 8'h00, 1'b1};
        vecs[1]  = '{1'b0, 16'h1234, 16'h1000, 8'hAA, 1'b0};
        vecs[2]  = '{1'b0, 16'h1234, 16'h0100, 8'h2A, 1'b0};
        vecs[3]  = '{1'b0, 16'h9999, 16'h0001, 8'h02, 1'b0};
        vecs[4]  = '{1'b1, 16'h0500, 16'h0499, 8'h15, 1'b0};
        vecs[5]  = '{1'b1, 16'h9999, 16'h0999, 8'h55, 1'b0};
        vecs[6]  = '{1'b1, 16'h9999, 16'h9999, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1};
        vecs[9]  = '{1'b1, 16'h0042, 16'h0041, 8'h01, 1'b0};
        vecs[10] = '{1'b1, 16'h00A5, 16'h0095, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 16'h1234, 16'h0909, 8'h02, 1'b0};
        vecs[12] = '{1'b1, 16'h9999, 16'h9990, 8'h01, 1'b0};
        vecs[13] = '{1'b0, 16'h1234, 16'h1234, 8'h02, 1'b0};

        a_clr = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b0;
        preset = '0; chain_en = 1'b1; digits_force = '0;
        cyc(3);
        check("reset_outputs", {mode_o, load_en_o, load_o, busy, done, tick_o}, 0);
        a_clr = 1'b1;
        cyc(2);
        check("idle_outputs", {mode_o, load_en_o, load_o, busy, done, tick_o}, 0);

`ifdef BCD_CTRL_AUTORELOAD_EN
        do_start(1'b0, 16'h0002);
        for (int rep = 0; rep < 2; rep++) begin
            for (int r = 2; r >= 0; r--) begin
                wait_tick(n);
                check("ar_tick_gap", n, TICK_DIV);
                check("ar_digits", digits, to_bcd(r));
            end
            cyc(1);
            check("ar_done_pulse", done, 1);
            if (rep == 0) begin
                load_q.push_back(16'h0002);
                cyc(1);
                check("ar_reload", load_en_o, 1);
                check("ar_done_low", done, 0);
            end else begin
                stop = 1'b1;
                cyc(1);
                stop = 1'b0;
                check("ar_stop_idle", {busy, done, load_en_o}, 0);
            end
        end
`else
        // Count down 12 -> 0.
        do_start(1'b0, 16'h0012);
        for (int r = 12; r >= 0; r--) begin
            wait_tick(n);
            check("down_tick_gap", n, TICK_DIV);
            check("down_digits", digits, to_bcd(r));
            em = (r == 0) ? 8'h00 : ((r % 10 == 0) ? 8'h0A : 8'h02);
            check("down_mode", mode_o, em);
        end
        cyc(1);
        check("down_done", done, 1);
        check("down_busy", busy, 0);
        cyc(3);
        check("down_done_hold", {done, mode_o}, 9'h100);

        // Count up 0 -> 100; dir/preset inputs change after the latch.
        do_start(1'b1, 16'h0100);
        dir = 1'b0;
        preset = 16'h0999;
        for (int r = 0; r <= 100; r++) begin
            wait_tick(n);
            check("up_tick_gap", n, TICK_DIV);
            check("up_digits", digits, to_bcd(r));
            em = (r == 100) ? 8'h00 : ((r % 100 == 99) ? 8'h15 : ((r % 10 == 9) ? 8'h05 : 8'h01));
            check("up_mode", mode_o, em);
        end
        cyc(1);
        check("up_done", done, 1);
        cyc(5);
        check("up_quiet_mode", mode_o, 0);
        check("up_hold_digits", digits, 16'h0100);

        // Clamped preset, then pause/resume.
        do_start(1'b0, 16'h00F3);
        preset = '0;
        wait_tick(n);
        check("clamp_first_gap", n, TICK_DIV);
        check("clamp_digits", digits, 16'h0093);
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("pause_busy", busy, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (tick_o || mode_o != 0) n++;
            cyc(1);
        end
        check("pause_silent", n, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_tick(n);
        check("resume_gap", n + 1, 2);
        check("resume_digits", digits, 16'h0092);
        check("resume_mode", mode_o, 8'h02);

        // Run on to 0x0007 then clear.
        for (int i = 0; i < 100; i++) begin
            wait_tick(n);
            if (digits == 16'h0007) break;
        end
        check("clr_reach_7", digits, 16'h0007);
        clear = 1'b1;
        load_q.push_back(16'h0000);
        cyc(1);
        clear = 1'b0;
        check("clr_strobe", load_en_o, 1);
        cyc(1);
        check("clr_idle", {busy, done, mode_o, load_en_o}, 0);
        check("clr_digits", digits, 0);

        // Mode/terminal decode against forced digit values.
        chain_en = 1'b0;
        for (int i = 0; i < 14; i++) begin
            digits_force = vecs[i].digits;
            mode_q.push_back(vecs[i].mode);
            do_start(vecs[i].dir, vecs[i].preset);
            wait_tick(n);
            check("vec_tick_gap", n, TICK_DIV);
            cyc(1);
            check($sformatf("vec%0d_done", i), done, vecs[i].done);
            clear = 1'b1;
            load_q.push_back(16'h0000);
            cyc(1);
            clear = 1'b0;
            cyc(1);
        end
        chain_en = 1'b1;
`endif

        // Asynchronous reset in the middle of RUN.
        do_start(1'b0, 16'h0050);
        wait_tick(n);
        wait_tick(n);
        @(posedge clk);
        #2;
        a_clr = 1'b0;
        #1;
        check("areset_outputs", {mode_o, load_en_o, load_o, busy, done, tick_o}, 0);
        check("areset_digits", digits, 0);
        cyc(2);
        a_clr = 1'b1;
        cyc(2);
        check("areset_idle", {mode_o, load_en_o, busy, done, tick_o}, 0);

        check("load_q_drained", load_q.size(), 0);
        check("mode_q_drained", mode_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
